// File: rtl/alu_if.sv
// Execute-stage bus between the scheduler and the per-thread ALU.
// The scheduler drives the operands and opcode, and the ALU returns its registered result.
interface alu_if;
    logic       io_execute;
    logic [3:0] io_operation;
    logic       io_compare;
    logic [7:0] io_rs;
    logic [7:0] io_rt;
    logic [7:0] io_output;

    modport master (
        output io_execute,
        output io_operation,
        output io_compare,
        output io_rs,
        output io_rt,
        input  io_output
    );

    modport slave (
        input  io_execute,
        input  io_operation,
        input  io_compare,
        input  io_rs,
        input  io_rt,
        output io_output
    );
endinterface

// File: rtl/alu.sv
// Per-thread 8-bit ALU for the execute stage: a single-cycle compare or arithmetic/logic result,
// registered on execute. All arithmetic is unsigned and truncated to 8 bits.
module alu (
    input  logic  clock,
    input  logic  reset,
    alu_if.slave  bus
);
    typedef enum logic [3:0] {
        OP_PASS = 4'd0,
        OP_AND  = 4'd1,
        OP_OR   = 4'd2,
        OP_XOR  = 4'd3,
        OP_ADD  = 4'd4,
        OP_MUL  = 4'd5,
        OP_SUB  = 4'd6,
        OP_DIV  = 4'd7,
        OP_MOD  = 4'd8,
        OP_SHL  = 4'd9,
        OP_SHR  = 4'd10,
        OP_NOT  = 4'd11,
        OP_MIN  = 4'd12,
        OP_MAX  = 4'd13
    } op_e;

    logic [7:0]  rs;
    logic [7:0]  rt;
    logic [15:0] product;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        gt;
    logic        eq;
    logic        lt;
    logic [7:0]  arith_result;
    logic [7:0]  result_next;
    logic [7:0]  output_reg;

    assign rs      = bus.io_rs;
    assign rt      = bus.io_rt;
    assign gt      = (rs > rt);
    assign eq      = (rs == rt);
    assign lt      = (rs < rt);
    assign product = rs * rt;

    // Divide-by-zero is defined rather than left as X, so the divider path is guarded here.
    assign quotient  = (rt == 8'd0) ? 8'hFF : (rs / rt);
    assign remainder = (rt == 8'd0) ? rs    : (rs % rt);

    always_comb begin
        arith_result = 8'h00;
        case (op_e'(bus.io_operation))
            OP_PASS: arith_result = rs;
            OP_AND:  arith_result = rs & rt;
            OP_OR:   arith_result = rs | rt;
            OP_XOR:  arith_result = rs ^ rt;
            OP_ADD:  arith_result = rs + rt;
            OP_MUL:  arith_result = product[7:0];
            OP_SUB:  arith_result = rs - rt;
            OP_DIV:  arith_result = quotient;
            OP_MOD:  arith_result = remainder;
            OP_SHL:  arith_result = rs << rt[2:0];
            OP_SHR:  arith_result = rs >> rt[2:0];
            OP_NOT:  arith_result = ~rs;
            OP_MIN:  arith_result = lt ? rs : rt;
            OP_MAX:  arith_result = gt ? rs : rt;
            default: arith_result = 8'h00;
        endcase
    end

    always_comb begin
        result_next = output_reg;
        if (bus.io_execute) begin
            result_next = bus.io_compare ? {5'b00000, gt, eq, lt} : arith_result;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            output_reg <= 8'h00;
        end else begin
            output_reg <= result_next;
        end
    end

    assign bus.io_output = output_reg;
endmodule

// File: tb/tb_alu.sv
// Directed bench for the ALU. Each step drives one operation and checks the registered result
// against a hand-computed value.
module tb_alu;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    alu_if bus ();

    alu dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] expected);
        checks++;
        assert (bus.io_output === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, bus.io_output, expected);
        end
        $display("%-12s out=%02h exp=%02h", tag, bus.io_output, expected);
    endtask

    task automatic drive(input logic ex, input logic cmp, input logic [3:0] op,
                         input logic [7:0] a, input logic [7:0] b);
        bus.io_execute   = ex;
        bus.io_compare   = cmp;
        bus.io_operation = op;
        bus.io_rs        = a;
        bus.io_rt        = b;
    endtask

    task automatic exec(input string tag, input logic cmp, input logic [3:0] op,
                        input logic [7:0] a, input logic [7:0] b, input logic [7:0] expected);
        @(negedge clock);
        drive(1'b1, cmp, op, a, b);
        @(posedge clock);
        #1;
        check(tag, expected);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        drive(1'b1, 1'b1, 4'd0, 8'd10, 8'd3);

        // Reset held low with execute active
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            check("reset_hold", 8'h00);
        end
        @(negedge clock);
        reset = 1'b1;
        drive(1'b0, 1'b1, 4'd0, 8'd10, 8'd3);
        @(posedge clock);
        #1;
        check("post_rst", 8'h00);

        exec("cmp_10_3",  1'b1, 4'd0, 8'd10,  8'd3,  8'h04);
        exec("cmp_3_10",  1'b1, 4'd0, 8'd3,   8'd10, 8'h01);
        exec("cmp_5_5",   1'b1, 4'd0, 8'd5,   8'd5,  8'h02);
        exec("cmp_255_2", 1'b1, 4'd0, 8'd255, 8'd2,  8'h04);

        exec("add_10_3",  1'b0, 4'd4, 8'd10,  8'd3,  8'h0D);
        exec("add_3_10",  1'b0, 4'd4, 8'd3,   8'd10, 8'h0D);
        exec("add_5_5",   1'b0, 4'd4, 8'd5,   8'd5,  8'h0A);
        exec("add_wrap",  1'b0, 4'd4, 8'd255, 8'd2,  8'h01);
        exec("mul_10_3",  1'b0, 4'd5, 8'd10,  8'd3,  8'h1E);
        exec("mul_5_5",   1'b0, 4'd5, 8'd5,   8'd5,  8'h19);
        exec("mul_trunc", 1'b0, 4'd5, 8'd255, 8'd2,  8'hFE);

        exec("hold_load", 1'b0, 4'd4, 8'd10,  8'd3,  8'h0D);
        @(negedge clock);
        drive(1'b0, 1'b0, 4'd5, 8'd255, 8'd2);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            check("hold", 8'h0D);
        end

        exec("pass",      1'b0, 4'd0,  8'h5A, 8'h11, 8'h5A);
        exec("and",       1'b0, 4'd1,  8'hF0, 8'h3C, 8'h30);
        exec("or",        1'b0, 4'd2,  8'hF0, 8'h3C, 8'hFC);
        exec("xor",       1'b0, 4'd3,  8'hF0, 8'h3C, 8'hCC);
        exec("sub_3_10",  1'b0, 4'd6,  8'd3,  8'd10, 8'hF9);
        exec("div_10_3",  1'b0, 4'd7,  8'd10, 8'd3,  8'h03);
        exec("div_by0",   1'b0, 4'd7,  8'd7,  8'd0,  8'hFF);
        exec("mod_10_3",  1'b0, 4'd8,  8'd10, 8'd3,  8'h01);
        exec("mod_by0",   1'b0, 4'd8,  8'd7,  8'd0,  8'h07);
        exec("shl_81_1",  1'b0, 4'd9,  8'h81, 8'd1,  8'h02);
        exec("shl_rt9",   1'b0, 4'd9,  8'h03, 8'd9,  8'h06);
        exec("shr_81_1",  1'b0, 4'd10, 8'h81, 8'd1,  8'h40);
        exec("not",       1'b0, 4'd11, 8'h5A, 8'h00, 8'hA5);
        exec("min",       1'b0, 4'd12, 8'd10, 8'd3,  8'h03);
        exec("max",       1'b0, 4'd13, 8'd10, 8'd3,  8'h0A);
        exec("op14",      1'b0, 4'd14, 8'd10, 8'd3,  8'h00);
        exec("max_200",   1'b0, 4'd13, 8'd2,  8'd200, 8'hC8);
        exec("op15",      1'b0, 4'd15, 8'd10, 8'd3,  8'h00);
        exec("cmp_op5",   1'b1, 4'd5,  8'd3,  8'd10, 8'h01);

        // Asynchronous reset between clock edges
        exec("mul_pre_rst", 1'b0, 4'd5, 8'd10, 8'd3, 8'h1E);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst", 8'h00);
        @(posedge clock);
        #1;
        check("rst_edge", 8'h00);
        @(negedge clock);
        reset = 1'b1;
        exec("after_rst", 1'b0, 4'd4, 8'd1, 8'd2, 8'h03);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
